sc_reg_serializer: RTL and testbench
====================================

SC_REG_SERIALIZER -- requirements
Module: sc_reg_serializer

Interface
REQ-001 Parameter: RegSERIAL_DATAWIDTH, default 8, width of the parallel input word (legal range 2..15).
REQ-002 Parameter: RegSERIAL_COUNTWIDTH, default 4, width of the bit counter; SHALL satisfy 2^COUNTWIDTH > DATAWIDTH.
REQ-003 SC_RegGENERAL_CLOCK_50  in  1  system clock; all state SHALL change on its rising edge only.
REQ-004 SC_RegGENERAL_RESET_InHigh  in  1  reset, asynchronous, active-high.
REQ-005 SC_RegSERIAL_start_InHigh  in  1  request to capture the input word and begin serialization.
REQ-006 SC_RegSERIAL_abort_InHigh  in  1  synchronous abort of the current transfer.
REQ-007 SC_RegSERIAL_data_InBUS  in  DATAWIDTH  parallel word, driven by the upstream general register output bus.
REQ-008 SC_RegSERIAL_serial_Out  out  1  serial data, MSB first.
REQ-009 SC_RegSERIAL_busy_Out  out  1  high while bits are being shifted out.
REQ-010 SC_RegSERIAL_done_Out  out  1  one-cycle pulse after the last bit.
REQ-011 SC_RegSERIAL_bitcount_OutBUS  out  COUNTWIDTH  number of bits still to send, including the bit currently on serial_Out.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 IDLE with start=1 and abort=0 at an edge: shift register <= data_InBUS, counter <= DATAWIDTH, next state SHIFT. The capture latency is one cycle.
REQ-014 IDLE with start=0: state, shift register and counter SHALL hold.
REQ-015 SHIFT: serial_Out SHALL equal shift register bit DATAWIDTH-1, busy_Out SHALL be 1, and bitcount_OutBUS SHALL equal the counter.
REQ-016 SHIFT with abort=0 and counter>1 at an edge: shift register shifts left one bit with 0 fill, and the counter decrements by 1.
REQ-017 SHIFT with abort=0 and counter==1 at an edge: next state DONE, counter <= 0, shift register <= 0.
REQ-018 A transfer SHALL therefore present exactly DATAWIDTH serial bits in DATAWIDTH consecutive cycles.
REQ-019 DONE: done_Out=1 for exactly one cycle and busy_Out=0. The next state SHALL be IDLE unconditionally.
REQ-020 The start input SHALL be ignored in SHIFT and DONE. Changes to data_InBUS after capture SHALL NOT affect the transfer.
REQ-021 abort=1 at any edge in any state: next state IDLE, shift register <= 0, counter <= 0, and no done pulse is issued.
REQ-022 Abort SHALL take priority over start when both are asserted in the same cycle.
REQ-023 In IDLE and DONE: serial_Out=0 and bitcount_OutBUS=0.
REQ-024 Outputs SHALL be decoded only from registered state, shift register and counter, with no combinational path from any input to any output.

Reset
REQ-025 On RESET_InHigh=1, without waiting for a clock edge, the block SHALL enter: state IDLE, shift register 0, counter 0, serial_Out 0, busy_Out 0, done_Out 0, bitcount_OutBUS 0.
REQ-026 Reset asserted mid-transfer SHALL discard the transfer with no done pulse. The first clock edge after reset release SHALL be able to accept start.

Verification
REQ-027 The bench SHALL use the default parameters (DATAWIDTH=8). Cycle 1 is the first edge after the start edge.
REQ-028 Basic transfer: data=8'hA5, start pulsed for 1 cycle.
- serial_Out over cycles 1..8 = 1,0,1,0,0,1,0,1.
- bitcount over cycles 1..8 = 8..1.
- busy high in cycles 1..8.
- done=1 in cycle 9 only.
REQ-029 Start ignored while busy: data=8'hFF then start held high for 12 cycles.
- Exactly one transfer of eight 1s, then done.
- A new transfer begins from the IDLE cycle that follows DONE.
- A data_InBUS change to 8'h00 during SHIFT SHALL NOT alter the output.
REQ-030 Abort: data=8'hC3, abort=1 in cycle 3.
- Cycle 4 is IDLE with serial=0, busy=0, bitcount=0.
- No done pulse is issued.
- Start together with abort in IDLE SHALL NOT start a transfer.
REQ-031 Asynchronous reset: reset asserted between edges in cycle 5 of an 8'h81 transfer.
- All outputs go to 0 immediately, before the next edge.
- After release, a start with data 8'h01 produces 0,0,0,0,0,0,0,1 and then done.
REQ-032 Boundary values:
- data=8'h00 yields eight 0 bits with busy high and done still pulsed.
- data=8'h80 yields 1 then seven 0s.
- Back-to-back: start re-asserted in the IDLE cycle after done starts the next transfer with a gap of exactly 2 cycles between transfers.

Source files
------------

// File: rtl/sc_reg_serializer.sv
// Purpose : loads a parallel register word and shifts it out MSB first, one bit per clock.
// Latency : first bit appears the cycle after the start edge; done pulses the cycle after the last bit.
// Backpressure: none; start is ignored while a transfer or its done cycle is in progress, and abort wins over start.
//
// Ports:
//   SC_RegGENERAL_CLOCK_50       system clock, rising edge
//   SC_RegGENERAL_RESET_InHigh   asynchronous active-high reset
//   SC_RegSERIAL_start_InHigh    capture data_InBUS and begin a transfer (IDLE only)
//   SC_RegSERIAL_abort_InHigh    synchronous abort, returns to IDLE without a done pulse
//   SC_RegSERIAL_data_InBUS      parallel word to send
//   SC_RegSERIAL_serial_Out      serial data, MSB first
//   SC_RegSERIAL_busy_Out        high while bits are being shifted out
//   SC_RegSERIAL_done_Out        one-cycle pulse after the last bit
//   SC_RegSERIAL_bitcount_OutBUS bits still to send, including the one on serial_Out
module sc_reg_serializer #(
    parameter int RegSERIAL_DATAWIDTH  = 8,
    parameter int RegSERIAL_COUNTWIDTH = 4
) (
    input  logic                            SC_RegGENERAL_CLOCK_50,
    input  logic                            SC_RegGENERAL_RESET_InHigh,
    input  logic                            SC_RegSERIAL_start_InHigh,
    input  logic                            SC_RegSERIAL_abort_InHigh,
    input  logic [RegSERIAL_DATAWIDTH-1:0]  SC_RegSERIAL_data_InBUS,
    output logic                            SC_RegSERIAL_serial_Out,
    output logic                            SC_RegSERIAL_busy_Out,
    output logic                            SC_RegSERIAL_done_Out,
    output logic [RegSERIAL_COUNTWIDTH-1:0] SC_RegSERIAL_bitcount_OutBUS
);

    localparam int DW = RegSERIAL_DATAWIDTH;
    localparam int CW = RegSERIAL_COUNTWIDTH;

    localparam logic [CW-1:0] CNT_FULL = CW'(DW);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [DW-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] shift_reg;
    logic [DW-1:0] shift_reg_nxt;
    logic [CW-1:0] bit_cnt;
    logic [CW-1:0] bit_cnt_nxt;

    // State register: the only place any state changes.
    always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_RESET_InHigh) begin
        if (SC_RegGENERAL_RESET_InHigh) begin
            state     <= ST_IDLE;
            shift_reg <= REG_ZERO;
            bit_cnt   <= CNT_ZERO;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_reg_nxt;
            bit_cnt   <= bit_cnt_nxt;
        end
    end

    // Next-state logic. Abort is checked first so it overrides start and
    // suppresses the done pulse from any state.
    always_comb begin
        state_nxt     = state;
        shift_reg_nxt = shift_reg;
        bit_cnt_nxt   = bit_cnt;

        if (SC_RegSERIAL_abort_InHigh) begin
            state_nxt     = ST_IDLE;
            shift_reg_nxt = REG_ZERO;
            bit_cnt_nxt   = CNT_ZERO;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (SC_RegSERIAL_start_InHigh) begin
                        state_nxt     = ST_SHIFT;
                        shift_reg_nxt = SC_RegSERIAL_data_InBUS;
                        bit_cnt_nxt   = CNT_FULL;
                    end
                end
                ST_SHIFT: begin
                    // Counter reaching one means the bit on the line now is the last.
                    if (bit_cnt == CNT_ONE) begin
                        state_nxt     = ST_DONE;
                        shift_reg_nxt = REG_ZERO;
                        bit_cnt_nxt   = CNT_ZERO;
                    end else begin
                        shift_reg_nxt = {shift_reg[DW-2:0], 1'b0};
                        bit_cnt_nxt   = bit_cnt - CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt     = ST_IDLE;
                    shift_reg_nxt = REG_ZERO;
                    bit_cnt_nxt   = CNT_ZERO;
                end
            endcase
        end
    end

    // Outputs are decoded purely from registered state, so no input reaches
    // an output combinationally.
    always_comb begin
        SC_RegSERIAL_serial_Out      = 1'b0;
        SC_RegSERIAL_busy_Out        = 1'b0;
        SC_RegSERIAL_done_Out        = 1'b0;
        SC_RegSERIAL_bitcount_OutBUS = CNT_ZERO;
        unique case (state)
            ST_SHIFT: begin
                SC_RegSERIAL_serial_Out      = shift_reg[DW-1];
                SC_RegSERIAL_busy_Out        = 1'b1;
                SC_RegSERIAL_bitcount_OutBUS = bit_cnt;
            end
            ST_DONE: begin
                SC_RegSERIAL_done_Out = 1'b1;
            end
            default: begin
                SC_RegSERIAL_serial_Out = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sc_reg_serializer.sv
module tb_sc_reg_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] data = 8'h00;
    logic       serial;
    logic       busy;
    logic       done;
    logic [3:0] bitcount;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    sc_reg_serializer #(
        .RegSERIAL_DATAWIDTH (8),
        .RegSERIAL_COUNTWIDTH(4)
    ) dut (
        .SC_RegGENERAL_CLOCK_50      (clk),
        .SC_RegGENERAL_RESET_InHigh  (rst),
        .SC_RegSERIAL_start_InHigh   (start),
        .SC_RegSERIAL_abort_InHigh   (abort),
        .SC_RegSERIAL_data_InBUS     (data),
        .SC_RegSERIAL_serial_Out     (serial),
        .SC_RegSERIAL_busy_Out       (busy),
        .SC_RegSERIAL_done_Out       (done),
        .SC_RegSERIAL_bitcount_OutBUS(bitcount)
    );

    // Model: the bits still owed to the line, front first, plus a flag for
    // the single done cycle that follows the last bit.
    bit pend[$];
    bit done_owed = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst || abort) begin
            pend.delete();
            done_owed = 1'b0;
        end else if (pend.size() > 0) begin
            void'(pend.pop_front());
            done_owed = (pend.size() == 0);
        end else if (done_owed) begin
            done_owed = 1'b0;
        end else if (start) begin
            for (int i = 7; i >= 0; i--) pend.push_back(data[i]);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_serial",   32'(serial),   32'((pend.size() > 0) ? pend[0] : 1'b0));
            chk("model_busy",     32'(busy),     32'(pend.size() > 0));
            chk("model_done",     32'(done),     32'(done_owed));
            chk("model_bitcount", 32'(bitcount), 32'(pend.size()));
        end
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic s, input logic b, input logic d, input logic [3:0] c);
        chk({name, "_serial"},   32'(serial),   32'(s));
        chk({name, "_busy"},     32'(busy),     32'(b));
        chk({name, "_done"},     32'(done),     32'(d));
        chk({name, "_bitcount"}, 32'(bitcount), 32'(c));
    endtask

    // Checks cycles 1..8 of a transfer of pat followed by the done cycle.
    // Caller has just issued tick() on the capture edge.
    task automatic chk_transfer(input string name, input logic [7:0] pat);
        for (int i = 1; i <= 8; i++) begin
            chk_out(name, pat[8-i], 1'b1, 1'b0, 4'(9 - i));
            tick();
        end
        chk_out({name, "_done"}, 1'b0, 1'b0, 1'b1, 4'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk_out("reset", 1'b0, 1'b0, 1'b0, 4'd0);
        rst = 1'b0;
        cmp_en = 1'b1;
        tick();
        chk_out("idle", 1'b0, 1'b0, 1'b0, 4'd0);

        // Basic A5 transfer
        data = 8'hA5;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_transfer("a5", 8'hA5);
        tick();
        chk_out("a5_after", 1'b0, 1'b0, 1'b0, 4'd0);

        // Start held for 12 cycles; data changes mid-transfer
        data = 8'hFF;
        start = 1'b1;
        tick();
        for (int i = 1; i <= 8; i++) begin
            if (i == 3) data = 8'h00;
            chk_out("ff", 1'b1, 1'b1, 1'b0, 4'(9 - i));
            tick();
        end
        chk_out("ff_done", 1'b0, 1'b0, 1'b1, 4'd0);
        tick();
        chk_out("ff_idle", 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        start = 1'b0;
        // Second transfer captured 8'h00 from the IDLE cycle
        chk_transfer("zero", 8'h00);
        tick();

        // Abort in cycle 3 of a C3 transfer
        data = 8'hC3;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_out("c3_c1", 1'b1, 1'b1, 1'b0, 4'd8);
        tick();
        tick();
        chk_out("c3_c3", 1'b0, 1'b1, 1'b0, 4'd6);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_out("abort_c4", 1'b0, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 10; i++) begin
            chk("abort_no_done", 32'(done), 32'd0);
            tick();
        end
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk_out("abort_vs_start", 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        chk_out("abort_vs_start2", 1'b0, 1'b0, 1'b0, 4'd0);

        // Asynchronous reset mid-transfer (cycle 5 of 81)
        data = 8'h81;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk_out("r81_c5", 1'b0, 1'b1, 1'b0, 4'd4);
        #1;
        rst = 1'b1;
        #1;
        chk_out("async_rst", 1'b0, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        data = 8'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_transfer("after_rst", 8'h01);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("rst_no_done", 32'(done), 32'd0);
            tick();
        end

        // 80 then back-to-back 3C
        data = 8'h80;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_transfer("b80", 8'h80);
        tick();
        chk_out("gap_idle", 1'b0, 1'b0, 1'b0, 4'd0);
        data = 8'h3C;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_transfer("b2b", 8'h3C);
        tick();
        tick();
        chk_out("final_idle", 1'b0, 1'b0, 1'b0, 4'd0);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
